// File: rtl/vbar_pkg.sv
// vbar_pkg
// Shared definitions for the volume bar renderer.
//   palette_t    : one colour scheme (background, border, low, mid, high), RGB565
//   get_palette  : maps the 2-bit scheme select onto one of four palettes
//   PEAK_COLOUR  : colour of the held peak segment, independent of scheme
package vbar_pkg;

    typedef struct packed {
        logic [15:0] bg;
        logic [15:0] border;
        logic [15:0] low;
        logic [15:0] mid;
        logic [15:0] high;
    } palette_t;

    localparam logic [15:0] PEAK_COLOUR = 16'hFFFF;

    function automatic palette_t get_palette(input logic [1:0] scheme);
        palette_t p;
        case (scheme)
            2'd0:    p = '{bg: 16'h0000, border: 16'h8410, low: 16'h07E0, mid: 16'hFFE0, high: 16'hF800};
            2'd1:    p = '{bg: 16'h0010, border: 16'hC618, low: 16'h001F, mid: 16'h07FF, high: 16'hF81F};
            2'd2:    p = '{bg: 16'h2104, border: 16'hFD20, low: 16'h03E0, mid: 16'hFBE0, high: 16'hA000};
            default: p = '{bg: 16'h4208, border: 16'hFFE0, low: 16'h07FF, mid: 16'hF81F, high: 16'hF800};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/volume_bar_render_if.sv
// volume_bar_render_if
// Groups the renderer's frame/pixel signals.
//   frame_tick  : one-cycle pulse per display frame
//   level_in    : CHANNELS packed levels of LW bits, channel 0 in the LSBs
//   scheme      : palette select
//   pixel_index : raster pixel number, row-major
//   pixel_data  : RGB565 colour of the pixel_index presented two cycles earlier
// There is no valid/ready handshake: the display controller presents a new
// pixel_index every cycle and pixel_data is a fixed-latency (2-cycle) response.
// master = display controller side, slave = renderer side.
interface volume_bar_render_if #(
    parameter int CHANNELS = 2,
    parameter int LW       = 5,
    parameter int IW       = 13
);
    logic                     frame_tick;
    logic [CHANNELS*LW-1:0]   level_in;
    logic [1:0]               scheme;
    logic [IW-1:0]            pixel_index;
    logic [15:0]              pixel_data;

    modport master (
        output frame_tick, level_in, scheme, pixel_index,
        input  pixel_data
    );

    modport slave (
        input  frame_tick, level_in, scheme, pixel_index,
        output pixel_data
    );
endinterface

// File: rtl/vbar_peak_tracker.sv
// vbar_peak_tracker
// Per-channel level sampler with optional peak hold.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   tick         : frame_tick; level_in is only sampled when high
//   level_in     : raw level, clamped to LEVELS
//   level        : level shown for the current frame
//   peak         : held peak segment (constant 0 when peak hold is not built)
// Build option: VBAR_PEAK_HOLD_EN enables the peak/hold registers.
module vbar_peak_tracker #(
    parameter  int LEVELS      = 16,
    parameter  int HOLD_FRAMES = 30,
    localparam int LW          = $clog2(LEVELS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          tick,
    input  logic [LW-1:0] level_in,
    output logic [LW-1:0] level,
    output logic [LW-1:0] peak
);

    logic [LW-1:0] level_clamped;
    assign level_clamped = (level_in > LW'(LEVELS)) ? LW'(LEVELS) : level_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            level <= '0;
        end else if (tick) begin
            level <= level_clamped;
        end
    end

`ifdef VBAR_PEAK_HOLD_EN
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    logic [HW-1:0] hold;

    // Peak compares against the level captured on this same tick.
    // In the decay branch level_clamped < peak, so peak-1 never drops below it.
    always_ff @(posedge clock) begin
        if (reset) begin
            peak <= '0;
            hold <= '0;
        end else if (tick) begin
            if (level_clamped >= peak) begin
                peak <= level_clamped;
                hold <= HW'(HOLD_FRAMES);
            end else if (hold != '0) begin
                hold <= hold - HW'(1);
            end else begin
                peak <= peak - LW'(1);
            end
        end
    end
`else
    assign peak = '0;
`endif

endmodule

// File: rtl/volume_bar_render.sv
// volume_bar_render
// Renders CHANNELS vertical segmented level bars inside a bordered frame.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : frame_tick, level_in, scheme, pixel_index in; pixel_data out
// Pipeline: stage 1 splits pixel_index into x/y (and captures scheme),
// stage 2 registers the colour, so pixel_data follows pixel_index by 2 cycles.
// Build option: VBAR_PEAK_HOLD_EN draws the held peak segment in PEAK_COLOUR.
module volume_bar_render
    import vbar_pkg::*;
#(
    parameter int WIDTH       = 96,
    parameter int HEIGHT      = 64,
    parameter int LEVELS      = 16,
    parameter int CHANNELS    = 2,
    parameter int BORDER      = 3,
    parameter int HOLD_FRAMES = 30
) (
    input  logic                clock,
    input  logic                reset,
    volume_bar_render_if.slave  bus
);

    localparam int LW      = $clog2(LEVELS + 1);
    localparam int XW      = $clog2(WIDTH);
    localparam int YW      = $clog2(HEIGHT);
    localparam int IW      = $clog2(WIDTH * HEIGHT);
    localparam int SLOT    = (WIDTH - 2 * BORDER) / CHANNELS;
    localparam int LOW_MAX = LEVELS * 5 / 16;
    localparam int MID_MAX = LEVELS * 10 / 16;

    if (HEIGHT < 2 * BORDER + 3 * LEVELS) begin : g_height_check
        $error("volume_bar_render: HEIGHT cannot hold LEVELS segments inside the border");
    end

    logic [LW-1:0] level_q [CHANNELS];
    logic [LW-1:0] peak_q  [CHANNELS];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        vbar_peak_tracker #(
            .LEVELS      (LEVELS),
            .HOLD_FRAMES (HOLD_FRAMES)
        ) u_tracker (
            .clock    (clock),
            .reset    (reset),
            .tick     (bus.frame_tick),
            .level_in (bus.level_in[c*LW +: LW]),
            .level    (level_q[c]),
            .peak     (peak_q[c])
        );
    end

    // Stage 1: coordinates. Scheme travels with the pixel so a palette change
    // lands on exactly the pixels issued after it.
    logic [XW-1:0] x_s1;
    logic [YW-1:0] y_s1;
    logic [1:0]    scheme_s1;

    always_ff @(posedge clock) begin
        if (reset) begin
            x_s1      <= '0;
            y_s1      <= '0;
            scheme_s1 <= '0;
        end else begin
            x_s1      <= XW'(bus.pixel_index % IW'(WIDTH));
            y_s1      <= YW'(bus.pixel_index / IW'(WIDTH));
            scheme_s1 <= bus.scheme;
        end
    end

    // Stage 2 colour lookup. rise counts rows up from the inner bottom edge
    // (bottom interior row = 1); segment k occupies rise 3k-2 and 3k-1 and
    // rise 3k is the gap row above it.
    palette_t    pal;
    int          xi, yi, rise, seg;
    logic        in_border, on_seg;
    logic [15:0] colour_d;

    always_comb begin
        pal       = get_palette(scheme_s1);
        xi        = int'(x_s1);
        yi        = int'(y_s1);
        rise      = HEIGHT - BORDER - yi;
        seg       = (rise + 2) / 3;
        in_border = (xi < BORDER) || (xi >= WIDTH - BORDER) ||
                    (yi < BORDER) || (yi >= HEIGHT - BORDER);
        on_seg    = (rise % 3 != 0) && (seg >= 1) && (seg <= LEVELS);
        colour_d  = pal.bg;
        if (in_border) begin
            colour_d = pal.border;
        end else if (on_seg) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if ((xi >= BORDER + c * SLOT + SLOT / 4) &&
                    (xi <= BORDER + c * SLOT + 3 * SLOT / 4 - 1)) begin
                    if (seg <= int'(level_q[c])) begin
                        if (seg <= LOW_MAX)      colour_d = pal.low;
                        else if (seg <= MID_MAX) colour_d = pal.mid;
                        else                     colour_d = pal.high;
                    end else if (seg == int'(peak_q[c])) begin
                        // seg > level here, so this is a peak above the bar
                        colour_d = PEAK_COLOUR;
                    end
                end
            end
        end
    end

    logic [15:0] pixel_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            pixel_q <= '0;
        end else begin
            pixel_q <= colour_d;
        end
    end

    assign bus.pixel_data = pixel_q;

endmodule

// File: doc/volume_bar_render.md
VOLUME_BAR_RENDER -- requirements
Module: volume_bar_render

Interface
REQ-001 SHALL provide parameter WIDTH, default 96, display width in pixels.
REQ-002 SHALL provide parameter HEIGHT, default 64, display height in pixels.
REQ-003 SHALL provide parameter LEVELS, default 16, segments per bar.
REQ-004 SHALL provide parameter CHANNELS, default 2, number of side-by-side bars.
REQ-005 SHALL provide parameter BORDER, default 3, frame border thickness in pixels.
REQ-006 SHALL provide parameter HOLD_FRAMES, default 30, frames for which the peak is held.
REQ-007 SHALL have port clock, input, 1, the only clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port frame_tick, input, 1, one-cycle pulse per display frame.
REQ-010 SHALL have port level_in, input, CHANNELS*LW, where LW=$clog2(LEVELS+1); one binary level per channel, channel 0 in the LSBs.
REQ-011 SHALL have port scheme, input, 2, palette select.
REQ-012 SHALL have port pixel_index, input, $clog2(WIDTH*HEIGHT), raster pixel number, row-major.
REQ-013 SHALL have port pixel_data, output, 16, registered RGB565 colour.

Function
REQ-014 SHALL split pixel_index into x=index%WIDTH and y=index/WIDTH in pipeline stage 1, and SHALL register the colour in stage 2; pixel_data SHALL reflect pixel_index 2 cycles later.
REQ-015 SHALL sample level_in only on a cycle with frame_tick=1; between ticks, the displayed level SHALL stay constant.
REQ-016 SHALL clamp each sampled level greater than LEVELS to LEVELS.
REQ-017 SHALL output the border colour where x<BORDER, x>=WIDTH-BORDER, y<BORDER or y>=HEIGHT-BORDER.
REQ-018 SHALL divide the interior into CHANNELS slots of width SLOT=(WIDTH-2*BORDER)/CHANNELS; channel c's bar SHALL span columns BORDER+c*SLOT+SLOT/4 to BORDER+c*SLOT+3*SLOT/4-1.
REQ-019 SHALL place segment k (1..LEVELS) on rows HEIGHT-BORDER-3k+1 and HEIGHT-BORDER-3k+2, with the row above each segment left as a background gap.
REQ-020 SHALL colour a lit segment low for k<=LEVELS*5/16, mid for k<=LEVELS*10/16, and high otherwise.
REQ-021 SHALL colour unlit segments, gaps and all other interior pixels with the background colour.
REQ-022 SHALL draw the peak segment (k=peak, peak>level) in the peak colour 16'hFFFF.
REQ-023 SHALL apply this peak rule per channel at each frame_tick:
- level>=peak: peak<=level and hold<=HOLD_FRAMES.
- else if hold>0: hold<=hold-1.
- else: peak<=peak-1, never below level.
REQ-024 SHALL, when a scheme change occurs, take effect 2 cycles later; scheme SHALL not affect level or peak state.
REQ-025 SHALL require HEIGHT>=2*BORDER+3*LEVELS, checked by elaboration assertion.

Reset
REQ-026 SHALL clear pixel_data, both pipeline stages, sampled levels, peaks and hold counters to 0 on reset.
REQ-027 SHALL ignore a frame_tick coincident with reset.
REQ-028 SHALL produce the first valid pixel_data 2 cycles after reset deasserts.

Configuration
REQ-029 SHALL, when VBAR_PEAK_HOLD_EN is defined, implement the peak and hold registers of REQ-022/023.
REQ-030 SHALL, when VBAR_PEAK_HOLD_EN is undefined, omit those registers and draw no peak colour.

Structure
REQ-031 SHALL place the four palettes (background, border, low, mid, high per scheme) and PEAK_COLOUR constant in package vbar_pkg.
REQ-032 SHALL implement the per-channel level/peak/hold tracker as sub-module vbar_peak_tracker, instantiated CHANNELS times.

Verification
REQ-033 SHALL cover reset: with reset high, pixel_data=0; release and index 0 -> border colour of scheme 0 after 2 cycles.
REQ-034 SHALL cover single segment (defaults): ch0 level 1 plus tick.
- index 5684 (y59,x20) -> low colour.
- index 5588 (y58) -> background.
- index 5724 (ch1, x60) -> background.
REQ-035 SHALL cover clamping: ch0 level_in 17 plus tick -> index 1460 (y15,x20, segment 16) -> high colour.
REQ-036 SHALL cover peak hold: ch0 level 10 at tick then 2 at each later tick.
- Index 3092 (y32,x20) -> 16'hFFFF for 30 ticks.
- Peak then falls 1 segment per tick, reaching 2 after 8 more ticks.
REQ-037 SHALL cover tick gating: changing level_in without frame_tick leaves all pixel_data values unchanged.
REQ-038 SHALL cover config off: without VBAR_PEAK_HOLD_EN, rerun REQ-036 -> index 3092 is background.
